fir_mc_ctrl: RTL and testbench
==============================

FIR_MC_CTRL -- requirements
Module: fir_mc_ctrl

Interface
REQ-001 SHALL have parameter MAX_CHANNELS, default 4, upper bound on channels per job (>=1).
REQ-002 SHALL have parameter MAX_TAPS, default 64, upper bound on runtime tap count (>=1).
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk_i and rst_ni.
REQ-004 Ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- clear_i  in  1  sync soft clear
- start_i  in  1  job start pulse from slave
- x_addr_i, h_addr_i, y_addr_i  in  32 each  base byte addresses
- ch_stride_i  in  32  byte offset between channels (x, y)
- signal_length_i  in  16  samples per channel (16-bit samples)
- nb_taps_i  in  $clog2(MAX_TAPS+1)  tap count
- nb_channels_i  in  $clog2(MAX_CHANNELS+1)  channels per job
- right_shift_i  in  6  datapath shift
- tap_done_i  in  1  tap buffer filled
- y_done_i  in  1  y sink done
- x_start_o, h_start_o, y_start_o  out  1 each  streamer req_start pulses
- x_base_o, h_base_o, y_base_o  out  32 each  streamer base addresses
- x_len_o, y_len_o  out  16 each  tot_len/d0_len in 32-bit words
- h_len_o  out  16  tap word count
- right_shift_o  out  6  datapath shift
- channel_o  out  $clog2(MAX_CHANNELS)  current channel
- busy_o  out  1  job active
- done_o  out  1  one-cycle job-done pulse (also evt)
- err_o  out  1  one-cycle invalid-config pulse

Function
REQ-005 FSM states SHALL be IDLE, TAP_LOAD, COMPUTE and NEXT.
REQ-006 IDLE with start_i SHALL latch all config inputs into shadow registers, set channel_o=0 and busy_o=1, and move to TAP_LOAD; x/h/y_start_o SHALL pulse high exactly one cycle, in the first TAP_LOAD cycle (registered).
REQ-007 TAP_LOAD with tap_done_i SHALL move to COMPUTE; y_done_i outside COMPUTE SHALL be ignored.
REQ-008 COMPUTE with y_done_i: on the last channel SHALL go to IDLE with done_o=1 for one cycle and busy_o=0; otherwise SHALL go to NEXT.
REQ-009 NEXT SHALL increment channel_o, add ch_stride_i (shadow) to x_base_o and y_base_o (32-bit wrap-around), and go to COMPUTE next cycle with x_start_o and y_start_o pulsed one cycle.
REQ-010 Word lengths SHALL be ceil division, (n+1)>>1, computed with a 17-bit intermediate: x_len_o = y_len_o from signal_length, h_len_o from nb_taps; 65535 samples SHALL give 32768.
REQ-011 nb_channels 0 SHALL be treated as 1; a value above MAX_CHANNELS SHALL be clamped to MAX_CHANNELS.
REQ-012 signal_length 0, nb_taps 0 or nb_taps > MAX_TAPS at start SHALL start no stream, and SHALL pulse err_o and done_o together the next cycle while remaining in IDLE.
REQ-013 start_i while busy_o=1 SHALL be ignored.
REQ-014 clear_i SHALL force IDLE next cycle: busy_o=0, channel_o=0, no done_o, start pulses suppressed; clear_i SHALL win over a simultaneous start_i.
REQ-015 Address, length and shift outputs SHALL stay stable from start until done/clear.

Reset
REQ-016 While rst_ni=0, all outputs SHALL be 0 and the state IDLE, regardless of clk_i.
REQ-017 Reset mid-job SHALL abandon the job without a done_o pulse.

Configuration
REQ-018 Macro FIR_PER_CHANNEL_TAPS_EN: when defined, NEXT SHALL advance h_base_o by 4*h_len_o, pulse h_start_o with x/y, and go to TAP_LOAD (not COMPUTE); when undefined, taps SHALL load once per job and h_base_o SHALL stay constant.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- 1 ch, len=7, taps=5, x=0x1000, h=0x2000, y=0x3000 -> starts one cycle after start_i; x_len=4, h_len=3; done_o one cycle after y_done_i.
- 3 ch, stride=0x100, x=0x1000 -> x_base 0x1000/0x1100/0x1200; exactly one done_o, after the third y_done_i.
- 2 ch, FIR_PER_CHANNEL_TAPS_EN defined, taps=5 -> second h_base=h+12, TAP_LOAD re-entered; undefined -> single h_start_o.
- len=0 or taps=MAX_TAPS+1 -> err_o and done_o same cycle; no start pulses.
- clear_i during COMPUTE of ch 1 -> IDLE next cycle; later y_done_i gives no done_o; a new start_i runs normally.
- start_i while busy, and y_done_i during TAP_LOAD -> both ignored; state unchanged.

Source files
------------

// File: rtl/fir_mc_ctrl.sv
// Multi-channel FIR job controller: sequences tap, x and y streamers per channel.
// Optional FIR_PER_CHANNEL_TAPS_EN reloads a fresh tap set for every channel.
module fir_mc_ctrl #(
    parameter int unsigned MAX_CHANNELS = 4,
    parameter int unsigned MAX_TAPS     = 64
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_ni,
    input  logic                                                  clear_i,
    input  logic                                                  start_i,
    input  logic [31:0]                                           x_addr_i,
    input  logic [31:0]                                           h_addr_i,
    input  logic [31:0]                                           y_addr_i,
    input  logic [31:0]                                           ch_stride_i,
    input  logic [15:0]                                           signal_length_i,
    input  logic [$clog2(MAX_TAPS+1)-1:0]                         nb_taps_i,
    input  logic [$clog2(MAX_CHANNELS+1)-1:0]                     nb_channels_i,
    input  logic [5:0]                                            right_shift_i,
    input  logic                                                  tap_done_i,
    input  logic                                                  y_done_i,
    output logic                                                  x_start_o,
    output logic                                                  h_start_o,
    output logic                                                  y_start_o,
    output logic [31:0]                                           x_base_o,
    output logic [31:0]                                           h_base_o,
    output logic [31:0]                                           y_base_o,
    output logic [15:0]                                           x_len_o,
    output logic [15:0]                                           y_len_o,
    output logic [15:0]                                           h_len_o,
    output logic [5:0]                                            right_shift_o,
    output logic [((MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1)-1:0] channel_o,
    output logic                                                  busy_o,
    output logic                                                  done_o,
    output logic                                                  err_o
);
    localparam int unsigned NCW = $clog2(MAX_CHANNELS + 1);
    localparam int unsigned CHW = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, TAP_LOAD, COMPUTE, NEXT} state_e;

    state_e           state_q, state_d;
    logic [CHW-1:0]   channel_q, channel_d, last_ch_q, last_ch_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             x_start_q, x_start_d, h_start_q, h_start_d, y_start_q, y_start_d;
    logic [31:0]      x_base_q, x_base_d, h_base_q, h_base_d, y_base_q, y_base_d;
    logic [31:0]      stride_q, stride_d;
    logic [15:0]      x_len_q, x_len_d, h_len_q, h_len_d;
    logic [5:0]       shift_q, shift_d;
    logic [NCW-1:0]   nb_ch_clamped;
    logic             cfg_bad;

    // Channel count normalised to 1..MAX_CHANNELS; degenerate lengths reject the job.
    always_comb begin
        nb_ch_clamped = nb_channels_i;
        if (nb_channels_i == '0) begin
            nb_ch_clamped = NCW'(1);
        end else if (32'(nb_channels_i) > MAX_CHANNELS) begin
            nb_ch_clamped = NCW'(MAX_CHANNELS);
        end
        cfg_bad = (signal_length_i == '0) || (nb_taps_i == '0) ||
                  (32'(nb_taps_i) > MAX_TAPS);
    end

    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        last_ch_d = last_ch_q;
        busy_d    = busy_q;
        x_base_d  = x_base_q;
        h_base_d  = h_base_q;
        y_base_d  = y_base_q;
        stride_d  = stride_q;
        x_len_d   = x_len_q;
        h_len_d   = h_len_q;
        shift_d   = shift_q;
        x_start_d = 1'b0;
        h_start_d = 1'b0;
        y_start_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (clear_i) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            channel_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && cfg_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (start_i) begin
                        x_base_d  = x_addr_i;
                        h_base_d  = h_addr_i;
                        y_base_d  = y_addr_i;
                        stride_d  = ch_stride_i;
                        // 16-bit samples packed two per word, rounded up.
                        x_len_d   = 16'((17'(signal_length_i) + 17'd1) >> 1);
                        h_len_d   = 16'((17'(nb_taps_i) + 17'd1) >> 1);
                        shift_d   = right_shift_i;
                        last_ch_d = CHW'(nb_ch_clamped - NCW'(1));
                        channel_d = '0;
                        busy_d    = 1'b1;
                        x_start_d = 1'b1;
                        h_start_d = 1'b1;
                        y_start_d = 1'b1;
                        state_d   = TAP_LOAD;
                    end
                end
                TAP_LOAD: begin
                    if (tap_done_i) state_d = COMPUTE;
                end
                COMPUTE: begin
                    if (y_done_i && (channel_q == last_ch_q)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (y_done_i) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    channel_d = channel_q + CHW'(1);
                    x_base_d  = x_base_q + stride_q;
                    y_base_d  = y_base_q + stride_q;
                    x_start_d = 1'b1;
                    y_start_d = 1'b1;
`ifdef FIR_PER_CHANNEL_TAPS_EN
                    h_base_d  = h_base_q + (32'(h_len_q) << 2);
                    h_start_d = 1'b1;
                    state_d   = TAP_LOAD;
`else
                    state_d   = COMPUTE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            channel_q <= '0;
            last_ch_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            x_start_q <= 1'b0;
            h_start_q <= 1'b0;
            y_start_q <= 1'b0;
            x_base_q  <= '0;
            h_base_q  <= '0;
            y_base_q  <= '0;
            stride_q  <= '0;
            x_len_q   <= '0;
            h_len_q   <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            channel_q <= channel_d;
            last_ch_q <= last_ch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            x_start_q <= x_start_d;
            h_start_q <= h_start_d;
            y_start_q <= y_start_d;
            x_base_q  <= x_base_d;
            h_base_q  <= h_base_d;
            y_base_q  <= y_base_d;
            stride_q  <= stride_d;
            x_len_q   <= x_len_d;
            h_len_q   <= h_len_d;
            shift_q   <= shift_d;
        end
    end

    assign x_start_o     = x_start_q;
    assign h_start_o     = h_start_q;
    assign y_start_o     = y_start_q;
    assign x_base_o      = x_base_q;
    assign h_base_o      = h_base_q;
    assign y_base_o      = y_base_q;
    assign x_len_o       = x_len_q;
    assign y_len_o       = x_len_q;
    assign h_len_o       = h_len_q;
    assign right_shift_o = shift_q;
    assign channel_o     = channel_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fir_mc_ctrl.sv
// Scoreboard bench for fir_mc_ctrl: every start/done/err pulse is matched against
// an expectation queued when the stimulus was driven.
module tb_fir_mc_ctrl;
    logic        clk, rst_n, clear_i, start_i, tap_done_i, y_done_i;
    logic [31:0] x_addr_i, h_addr_i, y_addr_i, ch_stride_i;
    logic [15:0] signal_length_i;
    logic [6:0]  nb_taps_i;
    logic [2:0]  nb_channels_i;
    logic [5:0]  right_shift_i;
    logic        x_start_o, h_start_o, y_start_o, busy_o, done_o, err_o;
    logic [31:0] x_base_o, h_base_o, y_base_o;
    logic [15:0] x_len_o, y_len_o, h_len_o;
    logic [5:0]  right_shift_o;
    logic [1:0]  channel_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [4:0]  flags;   // {x_start, h_start, y_start, done, err}
        logic [31:0] xb, hb, yb;
        logic [1:0]  ch;
        int          c;
    } exp_t;
    exp_t exp_q[$];

    fir_mc_ctrl #(.MAX_CHANNELS(4), .MAX_TAPS(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i),
        .x_addr_i(x_addr_i), .h_addr_i(h_addr_i), .y_addr_i(y_addr_i),
        .ch_stride_i(ch_stride_i), .signal_length_i(signal_length_i),
        .nb_taps_i(nb_taps_i), .nb_channels_i(nb_channels_i),
        .right_shift_i(right_shift_i), .tap_done_i(tap_done_i), .y_done_i(y_done_i),
        .x_start_o(x_start_o), .h_start_o(h_start_o), .y_start_o(y_start_o),
        .x_base_o(x_base_o), .h_base_o(h_base_o), .y_base_o(y_base_o),
        .x_len_o(x_len_o), .y_len_o(y_len_o), .h_len_o(h_len_o),
        .right_shift_o(right_shift_o), .channel_o(channel_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each observed pulse pops and checks the oldest expectation.
    always @(negedge clk) begin
        logic [4:0] f;
        exp_t e;
        f = {x_start_o, h_start_o, y_start_o, done_o, err_o};
        if (f != 5'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got flags=%b ch=%0d cyc=%0d, want no pulse", f, channel_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (f !== e.flags || cyc != e.c ||
                    (e.flags[4:2] != 3'b0 && (x_base_o !== e.xb || h_base_o !== e.hb ||
                                             y_base_o !== e.yb || channel_o !== e.ch))) begin
                    n_bad++;
                    $display("FAIL sb_evt: got flags=%b x=%h h=%h y=%h ch=%0d cyc=%0d, want flags=%b x=%h h=%h y=%h ch=%0d cyc=%0d",
                             f, x_base_o, h_base_o, y_base_o, channel_o, cyc,
                             e.flags, e.xb, e.hb, e.yb, e.ch, e.c);
                end
            end
        end
    end

    function automatic void push_exp(input logic [4:0] f, input logic [31:0] xb, hb, yb,
                                     input logic [1:0] ch, input int c);
        exp_t e;
        e.flags = f; e.xb = xb; e.hb = hb; e.yb = yb; e.ch = ch; e.c = c;
        exp_q.push_back(e);
    endfunction

    task automatic set_cfg(input logic [2:0] nch, input logic [31:0] x, h, y, stride,
                           input logic [15:0] len, input logic [6:0] taps, input logic [5:0] sh);
        nb_channels_i = nch; x_addr_i = x; h_addr_i = h; y_addr_i = y;
        ch_stride_i = stride; signal_length_i = len; nb_taps_i = taps; right_shift_i = sh;
    endtask

    task automatic tick_pulse(input int which);
        if (which == 0) start_i = 1'b1;
        else if (which == 1) tap_done_i = 1'b1;
        else if (which == 2) y_done_i = 1'b1;
        else clear_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; tap_done_i = 1'b0; y_done_i = 1'b0; clear_i = 1'b0;
    endtask

    // Full job with config scrambled right after start; expectations use the latched values.
    task automatic run_job(input logic [2:0] nch_in, input int nch_eff, input logic [31:0] x, h, y,
                           stride, input logic [15:0] len, input logic [6:0] taps);
        logic [31:0] hl, hb;
        logic [4:0]  nf;
        hl = (32'(taps) + 32'd1) >> 1;
        set_cfg(nch_in, x, h, y, stride, len, taps, 6'd5);
        @(negedge clk);
        push_exp(5'b11100, x, h, y, 2'd0, cyc + 1);
        tick_pulse(0);
        set_cfg(3'($urandom), $urandom, $urandom, $urandom, $urandom, 16'($urandom), 7'($urandom), 6'($urandom));
        for (int ch = 0; ch < nch_eff; ch++) begin
            repeat (2) @(negedge clk);
            tick_pulse(1);
            repeat (2) @(negedge clk);
`ifdef FIR_PER_CHANNEL_TAPS_EN
            hb = h + 32'd4 * hl * 32'(ch + 1);
            nf = 5'b11100;
`else
            hb = h;
            nf = 5'b10100;
`endif
            if (ch == nch_eff - 1)
                push_exp(5'b00010, 32'd0, 32'd0, 32'd0, 2'd0, cyc + 1);
            else
                push_exp(nf, x + stride * 32'(ch + 1), hb, y + stride * 32'(ch + 1), 2'(ch + 1), cyc + 2);
            tick_pulse(2);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_pending: got %0d unmatched expectations, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear_i = 0; start_i = 0; tap_done_i = 0; y_done_i = 0;
        set_cfg(3'd1, 32'h1000, 32'h2000, 32'h3000, 32'h100, 16'd7, 7'd5, 6'd3);
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({x_start_o, h_start_o, y_start_o, x_base_o, h_base_o, y_base_o, x_len_o, y_len_o,
             h_len_o, right_shift_o, channel_o, busy_o, done_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b x=%h len=%0d, want all zero", busy_o, x_base_o, x_len_o);
        end
        start_i = 1'b0;
        rst_n = 1'b1;
        drain("reset");
    endtask

    task automatic test_single_channel();
        set_cfg(3'd1, 32'h1000, 32'h2000, 32'h3000, 32'h100, 16'd7, 7'd5, 6'd3);
        @(negedge clk);
        push_exp(5'b11100, 32'h1000, 32'h2000, 32'h3000, 2'd0, cyc + 1);
        tick_pulse(0);
        n_cmp++;
        if (busy_o !== 1'b1 || x_len_o !== 16'd4 || y_len_o !== 16'd4 || h_len_o !== 16'd3 || right_shift_o !== 6'd3) begin
            n_bad++;
            $display("FAIL single_cfg: got busy=%b xl=%0d yl=%0d hl=%0d sh=%0d, want 1/4/4/3/3",
                     busy_o, x_len_o, y_len_o, h_len_o, right_shift_o);
        end
        @(negedge clk);
        tick_pulse(1);
        repeat (3) @(negedge clk);
        push_exp(5'b00010, 32'd0, 32'd0, 32'd0, 2'd0, cyc + 1);
        tick_pulse(2);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_at_done: got %b, want 0", busy_o);
        end
        drain("single");
    endtask

    task automatic test_multi_channel();
        run_job(3'd3, 3, 32'h1000, 32'h2000, 32'h3000, 32'h100, 16'd10, 7'd5);
        n_cmp++;
        if (x_len_o !== 16'd5 || h_len_o !== 16'd3 || x_base_o !== 32'h1200 || y_base_o !== 32'h3200 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL multi_final: got xl=%0d hl=%0d x=%h y=%h busy=%b, want 5/3/1200/3200/0",
                     x_len_o, h_len_o, x_base_o, y_base_o, busy_o);
        end
        drain("multi");
    endtask

    task automatic test_two_channel_taps();
        logic [31:0] hb1;
        logic [4:0]  nf;
`ifdef FIR_PER_CHANNEL_TAPS_EN
        hb1 = 32'h400C; nf = 5'b11100;
`else
        hb1 = 32'h4000; nf = 5'b10100;
`endif
        set_cfg(3'd2, 32'h100, 32'h4000, 32'h8000, 32'h40, 16'd16, 7'd5, 6'd1);
        @(negedge clk);
        push_exp(5'b11100, 32'h100, 32'h4000, 32'h8000, 2'd0, cyc + 1);
        tick_pulse(0);
        @(negedge clk);
        tick_pulse(1);
        @(negedge clk);
        push_exp(nf, 32'h140, hb1, 32'h8040, 2'd1, cyc + 2);
        tick_pulse(2);
        @(negedge clk);
        n_cmp++;
        if (h_base_o !== hb1 || channel_o !== 2'd1) begin
            n_bad++;
            $display("FAIL two_ch_hbase: got h=%h ch=%0d, want h=%h ch=1", h_base_o, channel_o, hb1);
        end
`ifdef FIR_PER_CHANNEL_TAPS_EN
        tick_pulse(2);
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b1 || channel_o !== 2'd1) begin
            n_bad++;
            $display("FAIL two_ch_tapload: got busy=%b ch=%0d, want busy=1 ch=1", busy_o, channel_o);
        end
        tick_pulse(1);
`endif
        @(negedge clk);
        push_exp(5'b00010, 32'd0, 32'd0, 32'd0, 2'd0, cyc + 1);
        tick_pulse(2);
        drain("two_ch");
    endtask

    task automatic test_errors();
        logic [15:0] lens[3] = '{16'd0, 16'd7, 16'd7};
        logic [6:0]  taps[3] = '{7'd5, 7'd0, 7'd65};
        for (int i = 0; i < 3; i++) begin
            set_cfg(3'd1, 32'h1000, 32'h2000, 32'h3000, 32'h100, lens[i], taps[i], 6'd0);
            @(negedge clk);
            push_exp(5'b00011, 32'd0, 32'd0, 32'd0, 2'd0, cyc + 1);
            tick_pulse(0);
            n_cmp++;
            if (busy_o !== 1'b0) begin
                n_bad++;
                $display("FAIL err_busy_%0d: got %b, want 0", i, busy_o);
            end
        end
        drain("errors");
    endtask

    task automatic test_bounds();
        set_cfg(3'd1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd65535, 7'd64, 6'd63);
        @(negedge clk);
        push_exp(5'b11100, 32'h0, 32'h0, 32'h0, 2'd0, cyc + 1);
        tick_pulse(0);
        n_cmp++;
        if (x_len_o !== 16'd32768 || h_len_o !== 16'd32 || right_shift_o !== 6'd63) begin
            n_bad++;
            $display("FAIL bounds_len: got xl=%0d hl=%0d sh=%0d, want 32768/32/63", x_len_o, h_len_o, right_shift_o);
        end
        tick_pulse(3);
        drain("bounds_a");
        run_job(3'd0, 1, 32'h10, 32'h20, 32'h30, 32'h8, 16'd1, 7'd1);
        run_job(3'd7, 4, 32'hFFFF_FF80, 32'h2000, 32'hFFFF_FFC0, 32'h100, 16'd3, 7'd64);
        n_cmp++;
        if (x_base_o !== 32'h0000_0280 || y_base_o !== 32'h0000_02C0 || x_len_o !== 16'd2) begin
            n_bad++;
            $display("FAIL bounds_wrap: got x=%h y=%h xl=%0d, want 00000280/000002c0/2", x_base_o, y_base_o, x_len_o);
        end
        drain("bounds");
    endtask

    task automatic test_clear();
        set_cfg(3'd2, 32'h1000, 32'h2000, 32'h3000, 32'h100, 16'd8, 7'd4, 6'd2);
        @(negedge clk);
        push_exp(5'b11100, 32'h1000, 32'h2000, 32'h3000, 2'd0, cyc + 1);
        tick_pulse(0);
        tick_pulse(1);
        @(negedge clk);
`ifdef FIR_PER_CHANNEL_TAPS_EN
        push_exp(5'b11100, 32'h1100, 32'h2008, 32'h3100, 2'd1, cyc + 2);
`else
        push_exp(5'b10100, 32'h1100, 32'h2000, 32'h3100, 2'd1, cyc + 2);
`endif
        tick_pulse(2);
        repeat (2) @(negedge clk);
        tick_pulse(3);
        n_cmp++;
        if (busy_o !== 1'b0 || channel_o !== 2'd0) begin
            n_bad++;
            $display("FAIL clear_idle: got busy=%b ch=%0d, want 0/0", busy_o, channel_o);
        end
        tick_pulse(2);
        start_i = 1'b1; clear_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; clear_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_over_start: got busy=%b, want 0", busy_o);
        end
        drain("clear_a");
        run_job(3'd1, 1, 32'h5000, 32'h6000, 32'h7000, 32'h0, 16'd4, 7'd2);
        drain("clear");
    endtask

    task automatic test_back_to_back();
        set_cfg(3'd1, 32'hA000, 32'hB000, 32'hC000, 32'h0, 16'd9, 7'd9, 6'd4);
        @(negedge clk);
        push_exp(5'b11100, 32'hA000, 32'hB000, 32'hC000, 2'd0, cyc + 1);
        tick_pulse(0);
        set_cfg(3'd2, 32'h1, 32'h2, 32'h3, 32'h4, 16'd1, 7'd1, 6'd0);
        tick_pulse(2);
        tick_pulse(0);
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b1 || x_base_o !== 32'hA000 || x_len_o !== 16'd5 || channel_o !== 2'd0) begin
            n_bad++;
            $display("FAIL ignore_in_tapload: got busy=%b x=%h xl=%0d ch=%0d, want 1/a000/5/0",
                     busy_o, x_base_o, x_len_o, channel_o);
        end
        tick_pulse(1);
        tick_pulse(0);
        @(negedge clk);
        push_exp(5'b00010, 32'd0, 32'd0, 32'd0, 2'd0, cyc + 1);
        tick_pulse(2);
        drain("b2b");
        set_cfg(3'd1, 32'h100, 32'h200, 32'h300, 32'h0, 16'd2, 7'd2, 6'd0);
        @(negedge clk);
        push_exp(5'b11100, 32'h100, 32'h200, 32'h300, 2'd0, cyc + 1);
        tick_pulse(0);
        tick_pulse(1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, x_base_o, x_len_o, channel_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_midjob: got busy=%b x=%h xl=%0d, want all zero", busy_o, x_base_o, x_len_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_pulse(2);
        drain("rst_mid");
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_multi_channel();
        test_two_channel_taps();
        test_errors();
        test_bounds();
        test_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
